// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - CAM match-vector capture, priority encoder and result FIFO
module cam_match_encoder #(
    parameter int ROWS       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(ROWS),
    parameter int CW         = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] match_in,
    input  logic            match_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_hit,
    output logic            out_multi,
    output logic [AW-1:0]   out_addr,
    output logic [CW-1:0]   out_count,
    output logic            overflow,
    input  logic            clr_ovf,
    output logic [15:0]     srch_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam logic [FW:0] DEPTH_V = (FW + 1)'(FIFO_DEPTH);

    logic            s1_valid;
    logic [ROWS-1:0] s1_vec;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [FW-1:0]   fcnt;
    logic [FW:0]     occ;

    logic            mem_hit   [FIFO_DEPTH];
    logic            mem_multi [FIFO_DEPTH];
    logic [AW-1:0]   mem_addr  [FIFO_DEPTH];
    logic [CW-1:0]   mem_count [FIFO_DEPTH];

    logic            enc_hit;
    logic            enc_multi;
    logic [AW-1:0]   enc_addr;
    logic [CW-1:0]   enc_count;

    logic            accept;
    logic            drop;
    logic            push;
    logic            pop;

    // Counting the stage-1 slot as occupied keeps the FIFO from ever overfilling.
    assign occ      = {1'b0, fcnt} + {{FW{1'b0}}, s1_valid};
    assign in_ready = occ < DEPTH_V;
    assign accept   = match_valid & in_ready;
    assign drop     = match_valid & ~in_ready;
    assign push     = s1_valid;
    assign out_valid = (fcnt != '0);
    assign pop      = out_valid & out_ready;

    always_comb begin
        enc_addr  = '0;
        enc_count = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (s1_vec[i]) begin
                enc_addr = AW'(i);
            end
            enc_count = enc_count + CW'(s1_vec[i]);
        end
        enc_hit   = |s1_vec;
        enc_multi = enc_count > CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_vec <= match_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_hit[i]   <= 1'b0;
                mem_multi[i] <= 1'b0;
                mem_addr[i]  <= '0;
                mem_count[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_hit[wr_ptr]   <= enc_hit;
                mem_multi[wr_ptr] <= enc_multi;
                mem_addr[wr_ptr]  <= enc_addr;
                mem_count[wr_ptr] <= enc_count;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            srch_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (accept) begin
                srch_cnt <= srch_cnt + 16'd1;
            end
        end
    end

    assign out_hit   = mem_hit[rd_ptr];
    assign out_multi = mem_multi[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];
    assign out_count = mem_count[rd_ptr];

endmodule

// File: tb/tb_cam_match_encoder.sv
// tb/tb_cam_match_encoder.sv - self-checking bench for cam_match_encoder
module tb_cam_match_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] match_in = '0;
    logic        match_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_hit;
    logic        out_multi;
    logic [3:0]  out_addr;
    logic [4:0]  out_count;
    logic        overflow;
    logic        clr_ovf = 1'b0;
    logic [15:0] srch_cnt;

    int checks = 0;
    int errors = 0;

    cam_match_encoder dut (
        .clk(clk), .rst_n(rst_n), .match_in(match_in), .match_valid(match_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_multi(out_multi), .out_addr(out_addr),
        .out_count(out_count), .overflow(overflow), .clr_ovf(clr_ovf),
        .srch_cnt(srch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic       multi;
        logic [3:0] addr;
        logic [4:0] count;
    } res_t;

    // Reference: a queue of finished results plus at most one search in flight.
    res_t        q[$];
    int          m_pend = 0;
    logic [15:0] m_vec = '0;
    int          m_ovf = 0;
    int          m_cnt = 0;

    function automatic res_t enc(logic [15:0] v);
        res_t r;
        r.count = 5'($countones(v));
        r.hit   = (v != 16'h0);
        r.multi = ($countones(v) > 1);
        r.addr  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r.addr = 4'(i);
        end
        return r;
    endfunction

    function automatic int m_ready();
        return ((q.size() + m_pend) < DEPTH) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_pend = 0;
            m_ovf  = 0;
            m_cnt  = 0;
        end else begin
            int rdy;
            int acc;
            rdy = m_ready();
            acc = (match_valid && rdy != 0) ? 1 : 0;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (m_pend != 0) q.push_back(enc(m_vec));
            if (match_valid && rdy == 0) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (acc != 0) m_cnt = (m_cnt + 1) % 65536;
            m_pend = acc;
            m_vec  = match_in;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), m_ready());
        chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
        chk("overflow", int'(overflow), m_ovf);
        chk("srch_cnt", int'(srch_cnt), m_cnt);
        chk("fcnt", int'(dut.fcnt), q.size());
        if (q.size() != 0) begin
            chk("head_hit", int'(out_hit), int'(q[0].hit));
            chk("head_multi", int'(out_multi), int'(q[0].multi));
            chk("head_addr", int'(out_addr), int'(q[0].addr));
            chk("head_count", int'(out_count), int'(q[0].count));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        match_valid = 1'b0;
        clr_ovf     = 1'b0;
        out_ready   = 1'b0;
        rst_n       = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input int hit, input int multi, input int addr,
                       input int count);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_hit"}, int'(out_hit), hit);
        chk({name, "_multi"}, int'(out_multi), multi);
        chk({name, "_addr"}, int'(out_addr), addr);
        chk({name, "_count"}, int'(out_count), count);
    endtask

    function automatic logic [15:0] rand_vec();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0:       v = 16'h0000;
            1:       v = 16'h0001 << $urandom_range(0, 15);
            2:       v = 16'($urandom);
            default: v = 16'($urandom) & 16'($urandom);
        endcase
        return v;
    endfunction

    logic [15:0] t2_vec [3];
    int          t2_exp [3][4];

    initial begin
        int acc_cnt;
        #1;
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        lit_zero: begin
            chk("rst_addr", int'(out_addr), 0);
            chk("rst_count", int'(out_count), 0);
            chk("rst_hit", int'(out_hit), 0);
        end

        // 1: single all-zero search
        out_ready   = 1'b1;
        match_valid = 1'b1;
        match_in    = 16'h0000;
        cyc();
        match_valid = 1'b0;
        cyc();
        lit("t1", 0, 0, 0, 0);
        chk("t1_srch_cnt", int'(srch_cnt), 1);
        cyc();

        // 2: encode checks, one result per cycle
        t2_vec[0] = 16'h0010; t2_exp[0] = '{1, 0, 4, 1};
        t2_vec[1] = 16'h8001; t2_exp[1] = '{1, 1, 0, 2};
        t2_vec[2] = 16'hFFFF; t2_exp[2] = '{1, 1, 0, 16};
        for (int i = 0; i < 5; i++) begin
            match_valid = (i < 3);
            if (i < 3) match_in = t2_vec[i];
            if (i >= 2) lit("t2", t2_exp[i-2][0], t2_exp[i-2][1], t2_exp[i-2][2], t2_exp[i-2][3]);
            cyc();
        end
        chk("t2_drained", int'(out_valid), 0);

        // 3: backpressure and drop
        do_reset();
        acc_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            match_valid = 1'b1;
            match_in    = 16'h0001 << k;
            acc_cnt += int'(in_ready);
            if (k == 4) chk("t3_ready_low", int'(in_ready), 0);
            cyc();
        end
        match_valid = 1'b0;
        chk("t3_accepts", acc_cnt, 4);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_srch_cnt", int'(srch_cnt), 4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lit("t3_drain", 1, 0, k, 1);
            cyc();
        end
        chk("t3_empty", int'(out_valid), 0);

        // 4: full FIFO with simultaneous push/pop across pointer wrap
        do_reset();
        for (int k = 0; k < 6; k++) begin
            match_valid = 1'b1;
            match_in    = 16'h0003 << k;
            cyc();
        end
        for (int k = 0; k < 10; k++) begin
            match_valid = 1'b1;
            match_in    = 16'h0001 << (k + 4);
            out_ready   = k[0] ? 1'b0 : 1'b1;
            cyc();
        end
        match_valid = 1'b0;
        out_ready   = 1'b1;
        for (int k = 0; k < 8; k++) cyc();

        // 5: overflow set beats clear
        do_reset();
        for (int k = 0; k < 4; k++) begin
            match_valid = 1'b1;
            match_in    = 16'h0100;
            cyc();
        end
        match_valid = 1'b0;
        cyc();
        chk("t5_pre_ovf", int'(overflow), 0);
        match_valid = 1'b1;
        clr_ovf     = 1'b1;
        cyc();
        chk("t5_set_wins", int'(overflow), 1);
        match_valid = 1'b0;
        cyc();
        chk("t5_cleared", int'(overflow), 0);
        clr_ovf = 1'b0;

        // 6: asynchronous reset with three results queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            match_valid = 1'b1;
            match_in    = 16'h1000 << k;
            cyc();
        end
        match_valid = 1'b0;
        cyc();
        cyc();
        chk("t6_queued", int'(dut.fcnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", int'(out_valid), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_srch_cnt", int'(srch_cnt), 0);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t6_no_stale", int'(out_valid), 0);
        end

        // randomized traffic against the reference
        do_reset();
        for (int n = 0; n < 400; n++) begin
            match_valid = ($urandom_range(0, 3) != 0);
            match_in    = rand_vec();
            out_ready   = ($urandom_range(0, 2) != 0);
            clr_ovf     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        match_valid = 1'b0;
        out_ready   = 1'b1;
        for (int k = 0; k < 8; k++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
